// File: rtl/rot_ahb_pkg.sv
// Shared AHB-Lite encodings, arbiter state type, data-phase attributes and
// the byte-lane enable helper for the DMA responder.
package rot_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned WAIT_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_WAIT    = 2'd1,
      ARB_GRANTED = 2'd2
   } arb_state_e;

   // Attributes captured at address-phase accept and used in the data phase
   typedef struct packed {
      logic       write;
      logic [2:0] size;
      logic [1:0] off;
   } dp_attr_t;

   // Lane mask for a transfer; misaligned offset bits are dropped
   function automatic logic [BE_W-1:0] byte_en(input logic [2:0] size,
                                                input logic [1:0] off);
      logic [BE_W-1:0] be;
      case (size)
         HSIZE_BYTE: be = BE_W'(4'b0001 << off);
         HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_resp_mem.sv
// Word RAM with per-byte write enables and a registered read port.
// Ports: clk/rst_n, write port (we, be, waddr, wdata), read port (re, raddr)
// with rdata updated on the edge where re is high and held otherwise.
module ahb_resp_mem
   import rot_ahb_pkg::*;
#(
   parameter int unsigned DEPTH  = 4096,
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Byte-lane write; array contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < int'(BE_W); b++) begin
            if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Read register sees pre-write contents on a same-edge collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ahb_dma_responder.sv
// AHB-Lite memory slave with single-master arbiter, programmable wait
// states, byte-enabled word memory and saturating transfer counters.
// Ports: I_HCLK/I_HRESET_N; AHB master side I_DMA_H* in, O_DMA_HRDATA/
// HREADY/HGRANT out; I_WAIT_CYCLES wait states per data phase;
// O_RD_COUNT/O_WR_COUNT completed transfers; O_SIZE_ERR sticky bad HSIZE.
module ahb_dma_responder
   import rot_ahb_pkg::*;
#(
   parameter int unsigned MEM_DEPTH   = 4096,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned GRANT_DELAY = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              I_HCLK,
   input  logic              I_HRESET_N,
   input  logic [31:0]       I_DMA_HADDR,
   input  logic [31:0]       I_DMA_HWDATA,
   input  logic [1:0]        I_DMA_HTRANS,
   input  logic [2:0]        I_DMA_HSIZE,
   input  logic [2:0]        I_DMA_HBURST,
   input  logic              I_DMA_HBUSREQ,
   input  logic              I_DMA_HWRITE,
   input  logic [3:0]        I_WAIT_CYCLES,
   output logic [31:0]       O_DMA_HRDATA,
   output logic              O_DMA_HREADY,
   output logic              O_DMA_HGRANT,
   output logic [CNT_W-1:0]  O_RD_COUNT,
   output logic [CNT_W-1:0]  O_WR_COUNT,
   output logic              O_SIZE_ERR
);

   arb_state_e          state_q, state_d;
   logic [WAIT_W-1:0]   dly_q, dly_d;
   logic                hgrant_q;

   logic                dp_valid_q;
   dp_attr_t            dp_q;
   logic [ADDR_W-1:0]   dp_idx_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                hready_q;

   logic [CNT_W-1:0]    rd_cnt_q, wr_cnt_q;
   logic                size_err_q;

   logic                fwd_hit_q;
   logic [DATA_W-1:0]   fwd_data_q;
   logic [BE_W-1:0]     fwd_be_q;

   logic                accept;
   logic                dp_end;
   logic                wr_commit;
   logic                size_bad;
   logic [ADDR_W-1:0]   acc_idx;
   logic                mem_re;
   logic [ADDR_W-1:0]   mem_raddr;
   logic [BE_W-1:0]     mem_be;
   logic [DATA_W-1:0]   mem_rdata;
   logic                fwd_hit_d;
   logic [DATA_W-1:0]   fwd_mask;
   logic                unused_ok;

   // Transfer decode
   assign accept    = hgrant_q && hready_q &&
                      (I_DMA_HTRANS == HTRANS_NONSEQ || I_DMA_HTRANS == HTRANS_SEQ);
   assign dp_end    = dp_valid_q && hready_q;
   assign wr_commit = dp_end && dp_q.write;
   assign size_bad  = (I_DMA_HSIZE > HSIZE_WORD);
   assign acc_idx   = I_DMA_HADDR[ADDR_W+1:2];
   assign mem_be    = byte_en(dp_q.size, dp_q.off);

   // Read at accept, and re-read on every wait-state edge of a read phase
   assign mem_re    = (accept && !I_DMA_HWRITE) ||
                      (dp_valid_q && !dp_q.write && wait_q != '0);
   assign mem_raddr = accept ? acc_idx : dp_idx_q;
   assign fwd_hit_d = accept && !I_DMA_HWRITE && wr_commit && (acc_idx == dp_idx_q);

   assign unused_ok = ^{I_DMA_HBURST, I_DMA_HADDR[31:ADDR_W+2]};

   ahb_resp_mem #(
      .DEPTH  (MEM_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (I_HCLK),
      .rst_n (I_HRESET_N),
      .we    (wr_commit),
      .be    (mem_be),
      .waddr (dp_idx_q),
      .wdata (I_DMA_HWDATA),
      .re    (mem_re),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   // Arbiter state register
   always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
      if (!I_HRESET_N) begin
         state_q  <= ARB_IDLE;
         dly_q    <= '0;
         hgrant_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dly_q    <= dly_d;
         hgrant_q <= (state_d == ARB_GRANTED);
      end
   end

   // Arbiter next state; grant rises on the edge the delay count reaches zero
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      case (state_q)
         ARB_IDLE: begin
            if (I_DMA_HBUSREQ) begin
               dly_d   = WAIT_W'(GRANT_DELAY);
               state_d = (GRANT_DELAY == 0) ? ARB_GRANTED : ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (!I_DMA_HBUSREQ) begin
               state_d = ARB_IDLE;
            end else if (dly_q <= WAIT_W'(1)) begin
               dly_d   = '0;
               state_d = ARB_GRANTED;
            end else begin
               dly_d   = dly_q - WAIT_W'(1);
            end
         end
         ARB_GRANTED: begin
            if (!I_DMA_HBUSREQ && I_DMA_HTRANS == HTRANS_IDLE && !dp_valid_q)
               state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Data-phase tracking and HREADY generation
   always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
      if (!I_HRESET_N) begin
         dp_valid_q <= 1'b0;
         dp_q       <= '0;
         dp_idx_q   <= '0;
         wait_q     <= '0;
         hready_q   <= 1'b1;
      end else if (accept) begin
         dp_valid_q <= 1'b1;
         dp_idx_q   <= acc_idx;
         dp_q.write <= I_DMA_HWRITE;
         dp_q.size  <= size_bad ? HSIZE_WORD : I_DMA_HSIZE;
         dp_q.off   <= I_DMA_HADDR[1:0];
         wait_q     <= I_WAIT_CYCLES;
         hready_q   <= (I_WAIT_CYCLES == '0);
      end else if (dp_end) begin
         dp_valid_q <= 1'b0;
         hready_q   <= 1'b1;
      end else if (dp_valid_q) begin
         wait_q     <= wait_q - WAIT_W'(1);
         hready_q   <= (wait_q == WAIT_W'(1));
      end
   end

   // Completion counters and sticky size error
   always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
      if (!I_HRESET_N) begin
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         size_err_q <= 1'b0;
      end else begin
         if (dp_end && !dp_q.write && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
         if (wr_commit && wr_cnt_q != '1)             wr_cnt_q <= wr_cnt_q + CNT_W'(1);
         if (accept && size_bad)                      size_err_q <= 1'b1;
      end
   end

   // Captured write bytes overlaid on a same-edge read of the committed word
   always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
      if (!I_HRESET_N) begin
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
         fwd_be_q   <= '0;
      end else if (mem_re) begin
         fwd_hit_q  <= fwd_hit_d;
         fwd_data_q <= I_DMA_HWDATA;
         fwd_be_q   <= mem_be;
      end
   end

   assign fwd_mask = {{8{fwd_be_q[3]}}, {8{fwd_be_q[2]}}, {8{fwd_be_q[1]}}, {8{fwd_be_q[0]}}};

   // Read data is a pure function of registers, so it holds between loads
   assign O_DMA_HRDATA = fwd_hit_q ? ((fwd_data_q & fwd_mask) | (mem_rdata & ~fwd_mask))
                                   : mem_rdata;
   assign O_DMA_HREADY = hready_q;
   assign O_DMA_HGRANT = hgrant_q;
   assign O_RD_COUNT   = rd_cnt_q;
   assign O_WR_COUNT   = wr_cnt_q;
   assign O_SIZE_ERR   = size_err_q;

endmodule

// File: tb/tb_ahb_dma_responder.sv
// Directed self-checking bench for ahb_dma_responder (default parameters).
module tb_ahb_dma_responder;

   localparam logic [1:0] T_IDLE   = 2'd0;
   localparam logic [1:0] T_NONSEQ = 2'd2;

   logic        clk;
   logic        rst_n;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic        hbusreq;
   logic        hwrite;
   logic [3:0]  wait_cycles;
   logic [31:0] hrdata;
   logic        hready;
   logic        hgrant;
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   logic        size_err;

   int          n_tests;
   int          n_fail;
   logic [31:0] rd;
   int          lows;

   ahb_dma_responder dut (
      .I_HCLK        (clk),
      .I_HRESET_N    (rst_n),
      .I_DMA_HADDR   (haddr),
      .I_DMA_HWDATA  (hwdata),
      .I_DMA_HTRANS  (htrans),
      .I_DMA_HSIZE   (hsize),
      .I_DMA_HBURST  (hburst),
      .I_DMA_HBUSREQ (hbusreq),
      .I_DMA_HWRITE  (hwrite),
      .I_WAIT_CYCLES (wait_cycles),
      .O_DMA_HRDATA  (hrdata),
      .O_DMA_HREADY  (hready),
      .O_DMA_HGRANT  (hgrant),
      .O_RD_COUNT    (rd_count),
      .O_WR_COUNT    (wr_count),
      .O_SIZE_ERR    (size_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single non-pipelined transfer; returns read data and HREADY-low count
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [3:0] waits,
                       output logic [31:0] rdata, output int nlow);
      htrans = T_NONSEQ; haddr = addr; hwrite = wr; hsize = size; wait_cycles = waits;
      tick();
      htrans = T_IDLE; hwdata = wdata;
      nlow = 0;
      @(negedge clk);
      while (!hready && nlow < 20) begin
         nlow++;
         @(negedge clk);
      end
      rdata = hrdata;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0; haddr = '0; hwdata = '0; htrans = T_IDLE; hsize = 3'd2;
      hburst = '0; hbusreq = 1'b0; hwrite = 1'b0; wait_cycles = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_hgrant", 32'(hgrant), 32'd0);
      check("rst_hready", 32'(hready), 32'd1);
      check("rst_hrdata", hrdata, 32'h0);
      check("rst_rdcnt", 32'(rd_count), 32'd0);
      check("rst_wrcnt", 32'(wr_count), 32'd0);
      check("rst_sizeerr", 32'(size_err), 32'd0);

      // Grant timing with GRANT_DELAY=2
      tick();
      hbusreq = 1'b1;
      tick(); check("grant_c1", 32'(hgrant), 32'd0);
      tick(); check("grant_c2", 32'(hgrant), 32'd0);
      tick(); check("grant_c3", 32'(hgrant), 32'd1);
      hbusreq = 1'b0;
      tick(); check("grant_drop", 32'(hgrant), 32'd0);
      hbusreq = 1'b1;
      repeat (3) tick();
      check("grant_again", 32'(hgrant), 32'd1);

      // Zero-wait write then read
      xfer(1'b1, 32'h40, 3'd2, 32'hDEADBEEF, 4'd0, rd, lows);
      check("zw_wr_lows", 32'(lows), 32'd0);
      xfer(1'b0, 32'h40, 3'd2, 32'h0, 4'd0, rd, lows);
      check("zw_rd_lows", 32'(lows), 32'd0);
      check("zw_rd_data", rd, 32'hDEADBEEF);
      check("zw_wrcnt", 32'(wr_count), 32'd1);
      check("zw_rdcnt", 32'(rd_count), 32'd1);

      // Three wait states on a read
      xfer(1'b0, 32'h40, 3'd2, 32'h0, 4'd3, rd, lows);
      check("ws_lows", 32'(lows), 32'd3);
      check("ws_data", rd, 32'hDEADBEEF);
      check("ws_rdcnt", 32'(rd_count), 32'd2);

      // Byte and halfword lanes
      xfer(1'b1, 32'h40, 3'd2, 32'h00000000, 4'd0, rd, lows);
      xfer(1'b1, 32'h41, 3'd0, 32'h0000AA00, 4'd0, rd, lows);
      xfer(1'b1, 32'h42, 3'd1, 32'h55660000, 4'd0, rd, lows);
      xfer(1'b0, 32'h40, 3'd2, 32'h0, 4'd0, rd, lows);
      check("lane_data", rd, 32'h5566AA00);

      // Pipelined write then read of the same word
      xfer(1'b1, 32'h80, 3'd2, 32'hCAFEF00D, 4'd0, rd, lows);
      htrans = T_NONSEQ; haddr = 32'h80; hwrite = 1'b1; hsize = 3'd2; wait_cycles = 4'd0;
      tick();
      hwdata = 32'h12345678; hwrite = 1'b0;
      tick();
      htrans = T_IDLE;
      check("fwd_hready", 32'(hready), 32'd1);
      check("fwd_data", hrdata, 32'h12345678);
      tick();
      check("fwd_hold", hrdata, 32'h12345678);
      xfer(1'b0, 32'h80, 3'd2, 32'h0, 4'd0, rd, lows);
      check("fwd_readback", rd, 32'h12345678);

      // Illegal HSIZE writes a full word and sets the sticky flag
      xfer(1'b1, 32'h100, 3'd2, 32'h00000000, 4'd0, rd, lows);
      check("serr_before", 32'(size_err), 32'd0);
      xfer(1'b1, 32'h101, 3'd3, 32'hA5A5A5A5, 4'd0, rd, lows);
      check("serr_set", 32'(size_err), 32'd1);
      xfer(1'b0, 32'h100, 3'd2, 32'h0, 4'd0, rd, lows);
      check("serr_data", rd, 32'hA5A5A5A5);
      check("cnt_wr", 32'(wr_count), 32'd8);
      check("cnt_rd", 32'(rd_count), 32'd6);

      // Reset during a five-wait write aborts it
      xfer(1'b1, 32'h200, 3'd2, 32'h11223344, 4'd0, rd, lows);
      htrans = T_NONSEQ; haddr = 32'h200; hwrite = 1'b1; hsize = 3'd2; wait_cycles = 4'd5;
      tick();
      htrans = T_IDLE; hwdata = 32'h99999999;
      tick(); tick();
      check("arst_pre_hready", 32'(hready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_hready", 32'(hready), 32'd1);
      check("arst_hgrant", 32'(hgrant), 32'd0);
      check("arst_wrcnt", 32'(wr_count), 32'd0);
      check("arst_sizeerr", 32'(size_err), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) tick();
      check("arst_regrant", 32'(hgrant), 32'd1);
      xfer(1'b0, 32'h200, 3'd2, 32'h0, 4'd0, rd, lows);
      check("arst_mem_kept", rd, 32'h11223344);
      check("arst_rdcnt", 32'(rd_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_dma_responder.md
Name: ahb_dma_responder

Overview:
- Synthesizable AHB-Lite slave with a single-master bus arbiter, modelling the system memory on the far end of the rotation engine's DMA port.
- Grants the bus on request, accepts pipelined address/data phases, and inserts programmable wait states.
- Serves reads from, and commits writes to, an internal byte-enabled word memory.
- Used in place of the bus fabric plus SRAM for block-level and subsystem simulation and FPGA bring-up.

Parameters:
- MEM_DEPTH, 4096, number of 32-bit words; must be a power of 2.
- ADDR_W, 12, log2(MEM_DEPTH); word index = HADDR[ADDR_W+1:2].
- GRANT_DELAY, 2, cycles from sampled HBUSREQ=1 to HGRANT=1; legal range 0..15.
- CNT_W, 16, width of the saturating transfer counters.

Ports:
- I_HCLK  in  1  bus clock.
- I_HRESET_N  in  1  reset: asynchronous, active-low.
- I_DMA_HADDR  in  32  address from master.
- I_DMA_HWDATA  in  32  write data, driven by master in the data phase.
- I_DMA_HTRANS  in  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- I_DMA_HSIZE  in  3  transfer size: 0 byte, 1 half, 2 word; others are illegal.
- I_DMA_HBURST  in  3  burst type; informational only, not decoded.
- I_DMA_HBUSREQ  in  1  bus request.
- I_DMA_HWRITE  in  1  1 = write, 0 = read.
- I_WAIT_CYCLES  in  4  wait states per data phase; sampled at address-phase accept.
- O_DMA_HRDATA  out  32  read data.
- O_DMA_HREADY  out  1  transfer done / slave ready.
- O_DMA_HGRANT  out  1  bus granted to the DMA master.
- O_RD_COUNT  out  CNT_W  completed reads, saturating.
- O_WR_COUNT  out  CNT_W  completed writes, saturating.
- O_SIZE_ERR  out  1  sticky flag: illegal HSIZE was seen.

Behaviour:
- Reset values: HGRANT=0, HREADY=1, HRDATA=0, both counters 0, SIZE_ERR=0, arbiter in IDLE, no data phase pending. Memory contents are not reset.
- Arbiter FSM, IDLE -> ARB -> GRANTED:
  - IDLE: when HBUSREQ=1, load the delay counter with GRANT_DELAY and go to ARB. If GRANT_DELAY=0, go straight to GRANTED, so HGRANT rises on the next cycle.
  - ARB: decrement each cycle. At 0, go to GRANTED and set HGRANT=1. If HBUSREQ drops while in ARB, return to IDLE.
  - GRANTED: return to IDLE and clear HGRANT only when HBUSREQ=0, HTRANS=IDLE and no data phase is pending. The grant is never removed mid-transfer.
- Address-phase accept condition: HGRANT=1 && HREADY=1 && HTRANS is NONSEQ or SEQ.
  - On accept, capture word index, byte offset HADDR[1:0], HSIZE and HWRITE.
  - Load the wait counter from I_WAIT_CYCLES.
  - IDLE/BUSY transfers open no data phase and never drive HREADY low.
- Data phase:
  - HREADY=0 while the wait counter is nonzero; it decrements each cycle.
  - HREADY=1 on the final cycle; with 0 waits this is the cycle immediately after accept.
  - A new address phase may be accepted in that same final cycle (pipelined, back-to-back).
- Write commit:
  - Happens at the edge ending the data phase (HREADY=1).
  - Byte enables: size 0 -> one lane at offset; size 1 -> lanes {off[1],0}+{0,1}; size 2 -> all lanes.
  - Misaligned offset bits are ignored (aligned down).
  - Increment WR_COUNT.
- Read data:
  - HRDATA is loaded from memory at the accept edge and at every wait-state edge.
  - It is valid and stable whenever HREADY=1 in a read data phase and holds its value otherwise.
  - Increment RD_COUNT at data-phase end.
- Forwarding: a read accepted in the same edge that commits a write to the same word returns the merged (post-write) bytes.
- Illegal HSIZE (3..7):
  - Set SIZE_ERR, treat the transfer as a word transfer and complete it normally.
  - SIZE_ERR clears only on reset.
- Addresses: the word index wraps modulo MEM_DEPTH; no error is raised.
- Counters: saturate at all-ones.
- Reset asserted mid-transfer: the pending transfer is aborted with no memory write, and all outputs return to their reset values immediately (asynchronous).

Decomposition:
- Package rot_ahb_pkg:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ).
  - HSIZE encodings.
  - Arbiter state enum (ARB_IDLE, ARB_WAIT, ARB_GRANTED).
  - Byte-enable function (size, offset) -> 4-bit mask.
- Sub-module ahb_resp_mem: MEM_DEPTH x 32 RAM with 4-bit byte write enable and synchronous read port. Write-to-read forwarding lives in the parent.

Test Plan:
- Grant timing: GRANT_DELAY=2, raise HBUSREQ at cycle 0 -> HGRANT=1 at cycle 3. Drop HBUSREQ with HTRANS=IDLE -> HGRANT=0 the next cycle.
- Zero-wait word write/read: write 0xDEADBEEF @0x40, then read @0x40 with WAIT=0 -> HREADY never low; HRDATA=0xDEADBEEF in the read data phase; WR_COUNT=1, RD_COUNT=1.
- Wait states: WAIT=3, read @0x40 -> HREADY low for exactly 3 cycles, then high with HRDATA=0xDEADBEEF.
- Byte/half lanes: memory 0x00000000; write byte 0xAA @0x41, then half 0x5566 @0x42, read @0x40 -> 0x5566AA00.
- Back-to-back forwarding: write 0x12345678 @0x80 immediately followed by read @0x80 (pipelined, 0 waits) -> HRDATA=0x12345678.
- Reset and error handling:
  - Assert I_HRESET_N=0 during a WAIT=5 write -> memory word unchanged, HREADY=1, HGRANT=0 immediately.
  - HSIZE=3 write -> SIZE_ERR=1 and full word written.
